// File: rtl/binary_median_stream.sv
// binary_median_stream: streaming KxK binary median filter with line buffers,
// interior-pixel coordinates and a frame-end wake-up decision.
// Optional macro MEDIAN_BYPASS_EN adds a bypass port that emits the centre pixel.
module binary_median_stream #(
    parameter int LINE_LEN  = 180,
    parameter int NUM_LINES = 240,
    parameter int K         = 3,
    parameter int CNT_W     = 13
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CNT_W-1:0]             threshold,
`ifdef MEDIAN_BYPASS_EN
    input  logic                         bypass,
`endif
    input  logic                         pixValid,
    input  logic                         pixIn,
    output logic                         pixReady,
    output logic                         medValid,
    output logic                         medData,
    output logic [$clog2(NUM_LINES)-1:0] medX,
    output logic [$clog2(LINE_LEN)-1:0]  medY,
    output logic [CNT_W-1:0]             activeCount,
    output logic                         frameDone,
    output logic                         wakeUp
);

    localparam int XW  = $clog2(NUM_LINES);
    localparam int YW  = $clog2(LINE_LEN);
    localparam int R   = (K - 1) / 2;
    localparam int NW  = K * K;
    localparam int PW  = $clog2(NW + 1);
    localparam int MAJ = (NW + 1) / 2;

    localparam logic [XW-1:0] X_LAST = XW'(NUM_LINES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LINE_LEN - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(K - 1);
    localparam logic [YW-1:0] Y_MIN  = YW'(K - 1);
    localparam logic [XW-1:0] X_OFF  = XW'(R);
    localparam logic [YW-1:0] Y_OFF  = YW'(R);
    localparam logic [PW-1:0] P_MAJ  = PW'(MAJ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // control and bookkeeping state
    logic [1:0]       r_state;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [CNT_W-1:0] r_thresh;
    logic [CNT_W-1:0] r_count;
    logic             r_wakeUp;
    logic             r_frameDone;

    // registered output pixel
    logic             r_medValid;
    logic             r_medData;
    logic [XW-1:0]    r_medX;
    logic [YW-1:0]    r_medY;

    // pixel storage: previous K-1 lines and previous K-1 window columns
    logic [LINE_LEN-1:0] r_line [K-1];
    logic [K-2:0]        r_win  [K];

    // datapath wires
    logic          w_accept;
    logic          w_startAcc;
    logic          w_lastPix;
    logic          w_interior;
    logic          w_emit;
    logic [K-1:0]  w_col;
    logic [K-1:0]  w_win_nx [K];
    logic [PW-1:0] w_ones;
    logic          w_major;
    logic          w_bit;

`ifdef MEDIAN_BYPASS_EN
    logic          r_bypass;
    logic          w_centre;
`endif

    assign pixReady    = (r_state == S_RUN);
    assign w_accept    = pixValid && pixReady;
    assign w_startAcc  = (r_state == S_IDLE) && start;
    assign w_lastPix   = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_interior  = (r_x >= X_MIN) && (r_y >= Y_MIN);
    assign w_emit      = w_accept && w_interior;

    assign medValid    = r_medValid;
    assign medData     = r_medData;
    assign medX        = r_medX;
    assign medY        = r_medY;
    assign activeCount = r_count;
    assign frameDone   = r_frameDone;
    assign wakeUp      = r_wakeUp;

    // frame sequencing: idle until start, run one frame, one done cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) r_state <= S_RUN;
                S_RUN:   if (w_accept && w_lastPix) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // per-frame configuration captured on an accepted start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_thresh <= '0;
        end else if (w_startAcc) begin
            r_thresh <= threshold;
        end
    end

`ifdef MEDIAN_BYPASS_EN
    // bypass mode is fixed for the whole frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bypass <= 1'b0;
        end else if (w_startAcc) begin
            r_bypass <= bypass;
        end
    end
`endif

    // raster position of the next pixel to be accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_startAcc) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_accept) begin
            if (r_y == Y_LAST) begin
                r_y <= '0;
                r_x <= (r_x == X_LAST) ? '0 : r_x + 1'b1;
            end else begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    // the new window column: incoming pixel plus the same column of older lines
    always_comb begin
        w_col    = '0;
        w_col[0] = pixIn;
        for (int i = 1; i < K; i++) begin
            w_col[i] = r_line[i-1][LINE_LEN-1];
        end
    end

    // line buffers form one long shift chain; contents are never reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line[0] <= {r_line[0][LINE_LEN-2:0], pixIn};
            for (int i = 1; i < K - 1; i++) begin
                r_line[i] <= {r_line[i][LINE_LEN-2:0], r_line[i-1][LINE_LEN-1]};
            end
        end
    end

    // full window as seen by the accepted pixel: stored columns plus new one
    always_comb begin
        for (int r = 0; r < K; r++) begin
            w_win_nx[r] = {r_win[r], w_col[r]};
        end
    end

    // keep the newest K-1 columns for the next pixel
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                r_win[r] <= w_win_nx[r][K-2:0];
            end
        end
    end

    // popcount of the window and majority decision
    always_comb begin
        w_ones = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w_ones = w_ones + PW'(w_win_nx[r][c]);
            end
        end
        w_major = (w_ones >= P_MAJ);
    end

`ifdef MEDIAN_BYPASS_EN
    assign w_centre = w_win_nx[R][R];
    assign w_bit    = r_bypass ? w_centre : w_major;
`else
    assign w_bit    = w_major;
`endif

    // register the filtered pixel and its centre coordinates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_medValid <= 1'b0;
            r_medData  <= 1'b0;
            r_medX     <= '0;
            r_medY     <= '0;
        end else begin
            r_medValid <= w_emit;
            if (w_emit) begin
                r_medData <= w_bit;
                r_medX    <= r_x - X_OFF;
                r_medY    <= r_y - Y_OFF;
            end
        end
    end

    // saturating count of emitted ones in the current frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_startAcc) begin
            r_count <= '0;
        end else if (w_emit && w_bit && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // frame-end pulse and wake-up decision, held until the next start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frameDone <= 1'b0;
            r_wakeUp    <= 1'b0;
        end else begin
            r_frameDone <= (r_state == S_DONE);
            if (w_startAcc) begin
                r_wakeUp <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_wakeUp <= (r_count > r_thresh);
            end
        end
    end

endmodule

// File: doc/binary_median_stream.md
# binary_median_stream

Streaming, parametrised K×K binary median filter for the event-image wake-up path. It is the next generation of the memory-based 3×3 median top:
- Pixels arrive in raster order through a valid/ready handshake rather than being written into an addressed frame memory.
- Line buffers hold the K−1 previous lines; window size and image dimensions are parameters.
- Each interior output pixel goes out with its coordinates for the downstream median memory.
- Ones in the filtered frame are counted against a threshold to raise wakeUp at frame end.

## Interface
- LINE_LEN, 180: pixels per line (inner, fast index y).
- NUM_LINES, 240: lines per frame (outer index x).
- K, 3: window size. Odd, 3 or 5.
- CNT_W, 13: width of threshold and activeCount.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle frame start request, honoured only in IDLE.
- threshold  in  CNT_W  wake-up threshold, sampled on accepted start.
- pixValid  in  1  input pixel valid.
- pixIn  in  1  binary input pixel.
- pixReady  out  1  block accepts a pixel this cycle.
- medValid  out  1  one-cycle strobe: medData/medX/medY valid (drives median-memory write).
- medData  out  1  filtered pixel.
- medX  out  clog2(NUM_LINES)  line index of window centre.
- medY  out  clog2(LINE_LEN)  pixel index of window centre.
- activeCount  out  CNT_W  ones emitted this frame, saturating.
- frameDone  out  1  one-cycle pulse after the last output of a frame.
- wakeUp  out  1  activeCount > threshold. Updated at frameDone; held until next accepted start.

## Operation
- R = (K−1)/2.
- A pixel is accepted on a clk edge with pixValid && pixReady.
- Input counters (x, y) advance per accepted pixel; y wraps at LINE_LEN−1 and increments x.
- K−1 line buffers, each LINE_LEN bits, shift on every accepted pixel. Buffer contents are not cleared by reset; the valid logic guarantees that stale data is never used.
- A K×K window register shifts in one column per accepted pixel.
- An output is generated when the accepted pixel completes an interior window: x ≥ K−1 and y ≥ K−1.
  - Centre coordinates: medX = x−R, medY = y−R.
  - Border pixels (centre within R of any edge) are not emitted.
  - Outputs per frame: (NUM_LINES−K+1)·(LINE_LEN−K+1).
- Median: ones = popcount(window), width clog2(K·K+1). medData = (ones ≥ (K·K+1)/2).
- activeCount increments on each emitted medData=1 and saturates at 2^CNT_W−1.
- States:
  - IDLE: pixReady=0. On start: latch threshold, clear x, y, activeCount, wakeUp; go to RUN.
  - RUN: pixReady=1; start is ignored. On acceptance of pixel (NUM_LINES−1, LINE_LEN−1), go to DONE.
  - DONE: pixReady=0. The final medValid appears in this cycle. Next cycle: frameDone=1 and wakeUp=(activeCount > threshold); return to IDLE.
- start and the last pixel arriving in the same cycle: start is ignored, because the block is in RUN.

## Timing
- medValid, medData, medX, medY are registered and appear one cycle after the completing pixel is accepted.
- pixValid gaps stall the pipeline. No output is produced without an accepted pixel, and outputs are unchanged in value and order.
- frameDone follows the final medValid by exactly 1 cycle.
- Start to first pixReady: 1 cycle.
- Reset values: pixReady, medValid, medData, medX, medY, activeCount, frameDone, wakeUp all 0; state IDLE.
- Reset asserted mid-frame clears all state immediately. The next start begins a clean frame.

## Configuration
- MEDIAN_BYPASS_EN defined:
  - Adds input port bypass (1 bit), sampled with start.
  - When bypass is latched high, medData = window centre pixel instead of the majority.
  - Coordinates, counting and timing are unchanged.
- MEDIAN_BYPASS_EN undefined: port absent; majority filtering always.

## Test plan
- Default parameters, all-ones frame, threshold=50:
  - 42364 medValid strobes, all medData=1.
  - activeCount saturates at 8191; wakeUp=1; one frameDone pulse.
- All-zeros frame, threshold=0: all medData=0, activeCount=0, wakeUp=0.
- Zero frame with single one at (5,5), K=3: salt is removed, so no medData=1 and wakeUp=0. Also run with K=5: same result.
- LINE_LEN=8, NUM_LINES=6, K=3, continuous valid:
  - First medValid one cycle after accepting (2,2), with medX=1, medY=1.
  - 24 outputs, last with (4,6).
  - frameDone one cycle after the last output.
- Same frame with pixValid toggled every cycle: output value and coordinate sequence identical to continuous run.
- reset pulsed low after 100 pixels:
  - All outputs 0 at once; pixReady=0.
  - New start plus full all-ones frame gives the correct count and a single frameDone.
